// File: rtl/dpram.sv
// dpram: true dual-port synchronous RAM with active-low chip, write and
// output enables on each port. Both ports share one clock. Reads are
// registered with one clock of latency and return the old contents on a
// same-edge write. When both ports write the same word on the same edge,
// port 1's data is stored.
module dpram #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 12
) (
   input  logic              CLK,
   input  logic              RESB,
   input  logic              nCE,
   input  logic              nWE,
   input  logic              nOE,
   input  logic [AWIDTH-1:0] A,
   input  logic [DWIDTH-1:0] DI,
   output logic [DWIDTH-1:0] DO,
   input  logic              nCE2,
   input  logic              nWE2,
   input  logic              nOE2,
   input  logic [AWIDTH-1:0] A2,
   input  logic [DWIDTH-1:0] DI2,
   output logic [DWIDTH-1:0] DO2
);

   localparam int DEPTH = 1 << AWIDTH;

   // The storage array has no reset. Its power-up contents are the block-RAM
   // default, which is all zero.
   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [DWIDTH-1:0] r_rd1;
   logic [DWIDTH-1:0] r_rd2;

   logic w_wr1;
   logic w_wr2;
   logic w_oe1;
   logic w_oe2;

   assign w_wr1 = ~nCE  & ~nWE;
   assign w_wr2 = ~nCE2 & ~nWE2;
   assign w_oe1 = ~nCE  & ~nOE;
   assign w_oe2 = ~nCE2 & ~nOE2;

   // Array writes, which are blocked while reset is held. Port 1 is written
   // last, so it wins when both ports write the same address.
   always_ff @(posedge CLK) begin
      if (RESB) begin
         if (w_wr2) r_mem[A2] <= DI2;
         if (w_wr1) r_mem[A]  <= DI;
      end
   end

   // Port 1 read register. It captures the pre-write contents whenever the
   // port is enabled, and holds its value while nCE is high.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB)     r_rd1 <= '0;
      else if (!nCE) r_rd1 <= r_mem[A];
   end

   // Port 2 read register. It uses the same rules as port 1.
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB)      r_rd2 <= '0;
      else if (!nCE2) r_rd2 <= r_mem[A2];
   end

   // Output gating follows the live enables. A deselected bus reads as all ones.
   always_comb begin
      DO  = w_oe1 ? r_rd1 : '1;
      DO2 = w_oe2 ? r_rd2 : '1;
   end

endmodule

// File: tb/tb_dpram.sv
// tb_dpram: directed vectors with hand-computed expectations for dpram.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point.
module tb_dpram;

   logic       CLK = 1'b0;
   logic       RESB;
   logic       nCE, nWE, nOE;
   logic [11:0] A;
   logic [7:0]  DI;
   logic [7:0]  DO;
   logic       nCE2, nWE2, nOE2;
   logic [11:0] A2;
   logic [7:0]  DI2;
   logic [7:0]  DO2;

   int total = 0;
   int bad   = 0;

   dpram #(.DWIDTH(8), .AWIDTH(12)) dut (
      .CLK(CLK), .RESB(RESB),
      .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DI(DI), .DO(DO),
      .nCE2(nCE2), .nWE2(nWE2), .nOE2(nOE2), .A2(A2), .DI2(DI2), .DO2(DO2)
   );

   always #5 CLK = ~CLK;

   // Count one comparison and report it if it mismatches.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end else begin
         $display("ok   %s: %02h", tag, got);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bound the run time.
   initial begin
      #100000;
      $display("FAIL timeout: got 00 expected 01");
      $fatal(1, "timeout");
   end

   initial begin
      RESB = 1'b0;
      nCE = 1'b1; nWE = 1'b1; nOE = 1'b1; A = '0; DI = '0;
      nCE2 = 1'b1; nWE2 = 1'b1; nOE2 = 1'b1; A2 = '0; DI2 = '0;
      tick(); tick();
      RESB = 1'b1;
      #1;

      // Idle and reset state.
      chk("idle_do", DO, 8'hFF);
      chk("idle_do2", DO2, 8'hFF);
      nCE = 1'b0; nOE = 1'b0; nCE2 = 1'b0; nOE2 = 1'b0;
      #1;
      chk("rst_rd1", DO, 8'h00);
      chk("rst_rd2", DO2, 8'h00);
      nCE2 = 1'b1; nOE2 = 1'b1;

      // Port 1 write, read, and output gating.
      A = 12'h123; DI = 8'hA5; nWE = 1'b0; nOE = 1'b1;
      tick();
      nWE = 1'b1; nOE = 1'b0;
      tick();
      chk("p1_read_123", DO, 8'hA5);
      nOE = 1'b1; #1;
      chk("p1_noe_high", DO, 8'hFF);
      nOE = 1'b0; #1;
      chk("p1_noe_low", DO, 8'hA5);

      // Read during write on the same port returns the old data.
      A = 12'h010; DI = 8'h11; nWE = 1'b0;
      tick();
      DI = 8'h22;
      tick();
      chk("rdw_old", DO, 8'h11);
      nWE = 1'b1;
      tick();
      chk("rdw_new", DO, 8'h22);

      // Cross-port traffic.
      A = 12'hFFF; DI = 8'h5A; nWE = 1'b0;
      tick();
      nWE = 1'b1; nCE = 1'b1;
      A2 = 12'hFFF; nCE2 = 1'b0; nOE2 = 1'b0;
      tick();
      chk("x_p2_read_fff", DO2, 8'h5A);
      nCE = 1'b0;
      A = 12'h001; DI = 8'h01; nWE = 1'b0;
      A2 = 12'h001; DI2 = 8'h02; nWE2 = 1'b0;
      tick();
      nWE = 1'b1; nWE2 = 1'b1;
      tick();
      chk("x_both_wr_p1", DO, 8'h01);
      chk("x_both_wr_p2", DO2, 8'h01);
      A = 12'h123; DI = 8'hB6; nWE = 1'b0;
      A2 = 12'h123;
      tick();
      chk("x_read_old", DO2, 8'hA5);
      nWE = 1'b1;
      tick();
      chk("x_read_new", DO2, 8'hB6);

      // An inactive port 2 with live-looking inputs must not write.
      nCE2 = 1'b1; nOE2 = 1'b1; nWE2 = 1'b0; A2 = 12'hFFF; DI2 = 8'h00;

      // Hold behaviour while nCE is high.
      A = 12'hFFF;
      tick();
      chk("hold_read_fff", DO, 8'h5A);
      nCE = 1'b1; A = 12'h123;
      tick(); tick(); tick();
      chk("hold_disabled", DO, 8'hFF);
      nCE = 1'b0; #1;
      chk("hold_rd1", DO, 8'h5A);
      tick();
      chk("hold_new_addr", DO, 8'hB6);
      nWE2 = 1'b1;
      A = 12'hFFF;
      tick();
      chk("p2_idle_nowrite", DO, 8'h5A);

      // Reset asserted during a write.
      A = 12'h200; DI = 8'h33; nWE = 1'b0;
      tick();
      nCE2 = 1'b0; nOE2 = 1'b0; A2 = 12'hFFF;
      nWE = 1'b1;
      tick();
      chk("pre_rst_p1", DO, 8'h33);
      chk("pre_rst_p2", DO2, 8'h5A);
      DI = 8'hEE; nWE = 1'b0;
      #2;
      RESB = 1'b0;
      #1;
      chk("rst_async_do", DO, 8'h00);
      chk("rst_async_do2", DO2, 8'h00);
      tick();
      chk("rst_hold_do", DO, 8'h00);
      nWE = 1'b1;
      RESB = 1'b1;
      tick();
      chk("rst_write_blocked", DO, 8'h33);
      chk("rst_p2_resume", DO2, 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
